uop_scheduler_n: RTL and testbench
==================================

Name: uop_scheduler_n

Overview:
- Parametrised N-stream micro-op scheduler for the 65HE06 core.
- Successor to the two-stream combinational selector.
- Buffers per-stream uops in small FIFOs and issues one uop per cycle to execute, over a valid/ready handshake.
- Tracks a round-robin "main" stream; while execute is doing memory, it may slot a hazard-free uop from another stream.

Parameters:
- NUM_STREAMS, 4, number of uop streams (>=2, power of 2); SW = $clog2(NUM_STREAMS) internal.
- UOP_W, 20, uop width (must be >=14).
- QDEPTH, 4, per-stream FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  NUM_STREAMS  per-stream uop offer.
- push_uop  in  NUM_STREAMS*UOP_W  per-stream uop; stream s at [s*UOP_W +: UOP_W].
- push_last  in  NUM_STREAMS  uop is last of its instruction.
- push_ready  out  NUM_STREAMS  stream FIFO not full.
- ex_doing_mem  in  1  execute stage busy with memory access.
- issue_valid  out  1  issue_uop valid.
- issue_ready  in  1  execute accepts.
- issue_uop  out  UOP_W  selected uop.
- issue_stream  out  SW  source stream index.
- issue_last  out  1  last flag of selected uop.
- issue_slot  out  1  1 = opportunistic (non-main) issue.
- main_stream  out  SW  current main pointer.
- q_empty  out  NUM_STREAMS  per-stream FIFO empty.

Behaviour:
- Uop fields:
  - bit13 = store.
  - [11:8] = dest reg (4b).
  - [2:0] = src0 and [5:3] = src1, each zero-extended to 4b for comparison; a dest >=8 never matches a source.
- Reset: all FIFOs empty, push_ready all 1, q_empty all 1, main_stream=0, issue_valid=0, issue_slot=0, all last_uop valid bits 0.
- FIFO:
  - Push when push_valid&push_ready; the entry {last,uop} is registered, so the earliest issue is the next cycle (1-cycle latency).
  - push_ready = ~full, with no same-cycle pop passthrough; a full queue refuses a push even while popping.
  - Pointers wrap modulo QDEPTH.
- Per-stream register last_uop[s] plus valid bit, loaded with the uop on every issue from stream s.
- Opportunistic candidate s (s != main) is eligible when all of the following hold:
  - head present;
  - head not store;
  - head not last;
  - main's last_uop not a valid store;
  - neither zero-extended src of head equals main's last_uop dest (when last_uop valid).
- Selection, combinational from FIFO heads:
  - if ex_doing_mem and any eligible candidate: choose the first in order main+1, main+2, … (mod N); issue_slot=1;
  - else if main head present: issue main head; issue_slot=0;
  - else issue_valid=0.
- Pop the selected head on issue_valid&issue_ready only. When not accepted, no state changes and the selection may change next cycle.
- Main advance:
  - On accepted main issue with issue_last=1, main_stream moves to the first stream after main (rr order) whose queue is non-empty after this cycle's pops/pushes are ignored, i.e. using the pre-update empty flags of other streams.
  - If none, main_stream holds.
- Opportunistic issues never move main_stream.
- Empty main with other streams non-empty: main_stream also advances using the same rr search (idle hand-off), taking 1 cycle and issuing nothing that cycle unless an opportunistic issue is eligible.
- Reset asserted mid-operation discards all queued uops immediately.

Optional Feature:
- SCHED_FLUSH_EN.
- Defined: adds input port flush (NUM_STREAMS).
  - flush[s] high empties FIFO s and clears last_uop[s] valid at the next clock edge.
  - flush overrides a same-cycle push to s.
  - If s == main, main advances as on the idle hand-off.
  - A stream being flushed is never selected in that cycle.
- Undefined: port absent; FIFOs drain only by issue.

Test Plan:
- Reset, push uop 0x00105 last=1 on stream 0 -> issue_valid=1 next cycle, issue_stream=0, issue_slot=0; after accept, main_stream stays 0 (others empty).
- Fill stream 1 with QDEPTH entries, issue_ready=0 -> push_ready[1]=0, fifth push held and not lost; one accept frees a slot the next cycle.
- Main=0 last issued dest=3; ex_doing_mem=1; stream 1 head src0=3, stream 2 head src0=1,src1=2 -> stream 2 issued, issue_slot=1, main_stream=0.
- Same setup but stream 2 head has bit13=1 or last=1 -> no opportunistic issue; main head issued if present.
- Streams 0,2,3 loaded, main=0 issues last=1 -> main_stream=2 (stream 1 empty skipped); then 3, then wraps to 0.
- SCHED_FLUSH_EN: flush[2]=1 with 3 queued and simultaneous push -> q_empty[2]=1 next cycle, no stream-2 issue.

Source files
------------

// File: rtl/uop_scheduler_n.sv
// N-stream uop scheduler: per-stream FIFOs, round-robin main stream, and
// hazard-free opportunistic issue while execute is in a memory op.
// Optional SCHED_FLUSH_EN adds a per-stream flush input.
module uop_scheduler_n #(
   parameter int  NUM_STREAMS = 4,
   parameter int  UOP_W       = 20,
   parameter int  QDEPTH      = 4,
   localparam int SW          = $clog2(NUM_STREAMS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_STREAMS-1:0]       push_valid,
   input  logic [NUM_STREAMS*UOP_W-1:0] push_uop,
   input  logic [NUM_STREAMS-1:0]       push_last,
   output logic [NUM_STREAMS-1:0]       push_ready,
`ifdef SCHED_FLUSH_EN
   input  logic [NUM_STREAMS-1:0]       flush,
`endif
   input  logic                         ex_doing_mem,
   output logic                         issue_valid,
   input  logic                         issue_ready,
   output logic [UOP_W-1:0]             issue_uop,
   output logic [SW-1:0]                issue_stream,
   output logic                         issue_last,
   output logic                         issue_slot,
   output logic [SW-1:0]                main_stream,
   output logic [NUM_STREAMS-1:0]       q_empty
);
   localparam int AW = $clog2(QDEPTH);

   logic [NUM_STREAMS-1:0]            empty, full, present, flush_w;
   logic [NUM_STREAMS-1:0]            head_last, elig, lv, lst;
   logic [NUM_STREAMS-1:0][UOP_W-1:0] head_uop;
   logic [NUM_STREAMS-1:0][3:0]       ldst;
   logic [SW-1:0]                     main_q, main_d, sel, slot_idx, rr_idx, idx;
   logic                              slot_found, rr_found, fire, adv;
   logic                              main_lv, main_st;
   logic [3:0]                        main_dst;

`ifdef SCHED_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = '0;
`endif

   // Per-stream FIFO plus the hazard-relevant fields of the last issued uop.
   for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_strm
      logic [AW:0]    wptr_q, rptr_q;
      logic [UOP_W:0] mem_q [QDEPTH];
      logic [3:0]     ldst_q;
      logic           lst_q, lv_q;
      logic           push, pop;

      assign empty[s]   = (wptr_q == rptr_q);
      assign full[s]    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      assign present[s] = ~empty[s] & ~flush_w[s];
      assign push       = push_valid[s] & ~full[s] & ~flush_w[s];
      assign pop        = fire & (sel == SW'(s));
      assign {head_last[s], head_uop[s]} = mem_q[rptr_q[AW-1:0]];
      assign ldst[s]    = ldst_q;
      assign lst[s]     = lst_q;
      assign lv[s]      = lv_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ldst_q <= '0;
            lst_q  <= 1'b0;
            lv_q   <= 1'b0;
         end else if (flush_w[s]) begin
            rptr_q <= wptr_q;
            lv_q   <= 1'b0;
         end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop) begin
               rptr_q <= rptr_q + (AW+1)'(1);
               ldst_q <= head_uop[s][11:8];
               lst_q  <= head_uop[s][13];
               lv_q   <= 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (push) mem_q[wptr_q[AW-1:0]] <= {push_last[s], push_uop[s*UOP_W +: UOP_W]};
      end
   end

   assign main_lv  = lv[main_q];
   assign main_st  = lst[main_q];
   assign main_dst = ldst[main_q];

   // Sources are 3 bits wide, so a dest >= 8 can never match.
   always_comb begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
         elig[s] = (SW'(s) != main_q) && present[s] && !head_uop[s][13] && !head_last[s]
                   && !(main_lv && main_st)
                   && !(main_lv && (({1'b0, head_uop[s][2:0]} == main_dst) ||
                                    ({1'b0, head_uop[s][5:3]} == main_dst)));
      end
   end

   // Walk from farthest to nearest so the nearest hit after main wins.
   always_comb begin
      idx        = main_q;
      slot_found = 1'b0;
      slot_idx   = main_q;
      rr_found   = 1'b0;
      rr_idx     = main_q;
      for (int k = NUM_STREAMS-1; k >= 1; k--) begin
         idx = main_q + SW'(k);
         if (elig[idx]) begin
            slot_found = 1'b1;
            slot_idx   = idx;
         end
         if (present[idx]) begin
            rr_found = 1'b1;
            rr_idx   = idx;
         end
      end
   end

   always_comb begin
      issue_valid = 1'b0;
      issue_slot  = 1'b0;
      sel         = main_q;
      if (ex_doing_mem && slot_found) begin
         issue_valid = 1'b1;
         issue_slot  = 1'b1;
         sel         = slot_idx;
      end else if (present[main_q]) begin
         issue_valid = 1'b1;
      end
   end

   assign issue_uop    = head_uop[sel];
   assign issue_last   = head_last[sel];
   assign issue_stream = sel;
   assign fire         = issue_valid & issue_ready;

   // Hand off on a completed main instruction or when main has nothing queued.
   assign adv    = (fire & ~issue_slot & issue_last) | ~present[main_q];
   assign main_d = (adv && rr_found) ? rr_idx : main_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) main_q <= '0;
      else        main_q <= main_d;
   end

   assign main_stream = main_q;
   assign push_ready  = ~full;
   assign q_empty     = empty;
endmodule

// File: tb/tb_uop_scheduler_n.sv
// Scoreboard bench for uop_scheduler_n: pushes are queued per stream and
// every accepted issue is checked in order; directed tasks check selection.
module tb_uop_scheduler_n;
   localparam int NS = 4;
   localparam int UW = 20;
   localparam int QD = 4;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NS-1:0]     push_valid = '0;
   logic [NS*UW-1:0]  push_uop = '0;
   logic [NS-1:0]     push_last = '0;
   logic [NS-1:0]     push_ready;
   logic [NS-1:0]     flush = '0;
   logic              ex_doing_mem = 1'b0;
   logic              issue_valid;
   logic              issue_ready = 1'b0;
   logic [UW-1:0]     issue_uop;
   logic [SW-1:0]     issue_stream;
   logic              issue_last;
   logic              issue_slot;
   logic [SW-1:0]     main_stream;
   logic [NS-1:0]     q_empty;

   int total = 0;
   int passed = 0;
   int issued = 0;
   logic [UW:0] sbq [NS][$];
   logic [UW:0] sb_exp;

   uop_scheduler_n #(.NUM_STREAMS(NS), .UOP_W(UW), .QDEPTH(QD)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_valid(push_valid), .push_uop(push_uop), .push_last(push_last),
      .push_ready(push_ready),
`ifdef SCHED_FLUSH_EN
      .flush(flush),
`endif
      .ex_doing_mem(ex_doing_mem), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_uop(issue_uop), .issue_stream(issue_stream), .issue_last(issue_last),
      .issue_slot(issue_slot), .main_stream(main_stream), .q_empty(q_empty)
   );

   always #5 clk = ~clk;

   // Scoreboard: record accepted pushes, check every accepted issue in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) sbq[s].delete();
      end else begin
         if (issue_valid && issue_ready) begin
            issued++;
            total++;
            if (sbq[issue_stream].size() == 0)
               $display("FAIL sb_issue: stream %0d issued %h, required no issue (queue empty)",
                        issue_stream, {issue_last, issue_uop});
            else begin
               sb_exp = sbq[issue_stream].pop_front();
               if ({issue_last, issue_uop} !== sb_exp)
                  $display("FAIL sb_issue: stream %0d got %h, required %h",
                           issue_stream, {issue_last, issue_uop}, sb_exp);
               else passed++;
            end
         end
         for (int s = 0; s < NS; s++) begin
`ifdef SCHED_FLUSH_EN
            if (flush[s]) sbq[s].delete();
            else
`endif
            if (push_valid[s] && push_ready[s])
               sbq[s].push_back({push_last[s], push_uop[s*UW +: UW]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid = '0; push_uop = '0; push_last = '0; flush = '0;
      ex_doing_mem = 1'b0; issue_ready = 1'b0;
   endtask

   task automatic set_push(input int s, input logic [UW-1:0] u, input logic l);
      push_valid[s] = 1'b1;
      push_uop[s*UW +: UW] = u;
      push_last[s] = l;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      issued = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #1;
      total++; if (push_ready !== 4'hF) $display("FAIL rst_push_ready: got %h, required f", push_ready); else passed++;
      total++; if (q_empty !== 4'hF) $display("FAIL rst_q_empty: got %h, required f", q_empty); else passed++;
      total++; if (main_stream !== 2'd0) $display("FAIL rst_main: got %0d, required 0", main_stream); else passed++;
      total++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %b, required 0", issue_valid); else passed++;
      total++; if (issue_slot !== 1'b0) $display("FAIL rst_issue_slot: got %b, required 0", issue_slot); else passed++;
      do_reset();
      @(negedge clk);
      total++; if (issue_valid !== 1'b0) $display("FAIL post_rst_valid: got %b, required 0", issue_valid); else passed++;
      total++; if (main_stream !== 2'd0) $display("FAIL post_rst_main: got %0d, required 0", main_stream); else passed++;
      tick();
   endtask

   task automatic test_basic();
      do_reset();
      set_push(0, 20'h00105, 1'b1);
      tick();
      idle();
      issue_ready = 1'b1;
      @(negedge clk);
      total++; if (issue_valid !== 1'b1) $display("FAIL basic_valid: got %b, required 1", issue_valid); else passed++;
      total++; if (issue_stream !== 2'd0) $display("FAIL basic_stream: got %0d, required 0", issue_stream); else passed++;
      total++; if (issue_slot !== 1'b0) $display("FAIL basic_slot: got %b, required 0", issue_slot); else passed++;
      total++; if (issue_uop !== 20'h00105) $display("FAIL basic_uop: got %h, required 00105", issue_uop); else passed++;
      tick();
      @(negedge clk);
      total++; if (main_stream !== 2'd0) $display("FAIL basic_main: got %0d, required 0", main_stream); else passed++;
      total++; if (q_empty[0] !== 1'b1) $display("FAIL basic_empty: got %b, required 1", q_empty[0]); else passed++;
      total++; if (issue_valid !== 1'b0) $display("FAIL basic_drained: got %b, required 0", issue_valid); else passed++;
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int n = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         set_push(1, 20'h00200 + 20'(acc), 1'b0);
         @(negedge clk);
         if (push_ready[1]) acc++;
         tick();
      end
      total++; if (acc !== QD) $display("FAIL bp_accepted: got %0d, required %0d", acc, QD); else passed++;
      @(negedge clk);
      total++; if (push_ready[1] !== 1'b0) $display("FAIL bp_full: got %b, required 0", push_ready[1]); else passed++;
      total++; if (main_stream !== 2'd1) $display("FAIL bp_handoff: got %0d, required 1", main_stream); else passed++;
      tick();
      issue_ready = 1'b1;
      @(negedge clk);
      total++; if (issue_stream !== 2'd1 || issue_valid !== 1'b1)
         $display("FAIL bp_issue: got valid %b stream %0d, required valid 1 stream 1", issue_valid, issue_stream);
      else passed++;
      total++; if (push_ready[1] !== 1'b0) $display("FAIL bp_no_passthru: got %b, required 0", push_ready[1]); else passed++;
      tick();
      issue_ready = 1'b0;
      @(negedge clk);
      total++; if (push_ready[1] !== 1'b1) $display("FAIL bp_freed: got %b, required 1", push_ready[1]); else passed++;
      tick();
      idle();
      issue_ready = 1'b1;
      while (n < 20) begin
         @(negedge clk);
         if (q_empty[1]) break;
         n++;
         tick();
      end
      total++; if (q_empty[1] !== 1'b1) $display("FAIL bp_drain_timeout: got q_empty %b, required 1", q_empty[1]); else passed++;
      total++; if (issued !== QD + 1) $display("FAIL bp_issue_count: got %0d, required %0d", issued, QD + 1); else passed++;
      idle();
      tick();
   endtask

   // Main stream 0 issues a uop writing r3, keeping a second uop queued.
   task automatic slot_prelude(input logic [UW-1:0] s2_uop, input logic s2_last);
      do_reset();
      set_push(0, 20'h00300, 1'b0);
      tick();
      set_push(0, 20'h00400, 1'b0);
      tick();
      idle();
      issue_ready = 1'b1;
      tick();
      idle();
      set_push(1, 20'h00003, 1'b0);
      set_push(2, s2_uop, s2_last);
      tick();
      idle();
      ex_doing_mem = 1'b1;
      issue_ready = 1'b1;
   endtask

   task automatic test_slot();
      slot_prelude(20'h00011, 1'b0);
      @(negedge clk);
      total++; if (issue_valid !== 1'b1 || issue_stream !== 2'd2)
         $display("FAIL slot_stream: got valid %b stream %0d, required valid 1 stream 2", issue_valid, issue_stream);
      else passed++;
      total++; if (issue_slot !== 1'b1) $display("FAIL slot_flag: got %b, required 1", issue_slot); else passed++;
      total++; if (issue_uop !== 20'h00011) $display("FAIL slot_uop: got %h, required 00011", issue_uop); else passed++;
      tick();
      @(negedge clk);
      total++; if (main_stream !== 2'd0) $display("FAIL slot_main_held: got %0d, required 0", main_stream); else passed++;
      total++; if (issue_stream !== 2'd0 || issue_slot !== 1'b0)
         $display("FAIL slot_then_main: got stream %0d slot %b, required stream 0 slot 0", issue_stream, issue_slot);
      else passed++;
      total++; if (issue_uop !== 20'h00400) $display("FAIL slot_then_main_uop: got %h, required 00400", issue_uop); else passed++;
      idle();
      tick();
   endtask

   task automatic test_slot_blocked();
      for (int v = 0; v < 2; v++) begin
         slot_prelude((v == 0) ? 20'h02011 : 20'h00011, (v == 1));
         @(negedge clk);
         total++; if (issue_stream !== 2'd0 || issue_valid !== 1'b1)
            $display("FAIL blocked_stream v%0d: got valid %b stream %0d, required valid 1 stream 0", v, issue_valid, issue_stream);
         else passed++;
         total++; if (issue_slot !== 1'b0) $display("FAIL blocked_slot v%0d: got %b, required 0", v, issue_slot); else passed++;
         total++; if (issue_uop !== 20'h00400) $display("FAIL blocked_uop v%0d: got %h, required 00400", v, issue_uop); else passed++;
         idle();
         tick();
      end
   endtask

   task automatic test_rr();
      int exp_s [4] = '{0, 2, 3, 0};
      do_reset();
      set_push(0, 20'h00501, 1'b1);
      set_push(2, 20'h00502, 1'b1);
      set_push(3, 20'h00503, 1'b1);
      tick();
      idle();
      set_push(0, 20'h00504, 1'b1);
      tick();
      idle();
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if (main_stream !== 2'(exp_s[i]))
            $display("FAIL rr_main step%0d: got %0d, required %0d", i, main_stream, exp_s[i]);
         else passed++;
         total++; if (issue_valid !== 1'b1 || issue_stream !== 2'(exp_s[i]))
            $display("FAIL rr_issue step%0d: got valid %b stream %0d, required valid 1 stream %0d", i, issue_valid, issue_stream, exp_s[i]);
         else passed++;
         tick();
      end
      @(negedge clk);
      total++; if (main_stream !== 2'd0) $display("FAIL rr_hold: got %0d, required 0", main_stream); else passed++;
      total++; if (issue_valid !== 1'b0) $display("FAIL rr_idle: got %b, required 0", issue_valid); else passed++;
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_push(1, 20'h00701, 1'b0);
      set_push(3, 20'h00703, 1'b0);
      tick();
      tick();
      idle();
      total++; if (q_empty !== 4'b0101) $display("FAIL mid_loaded: got %b, required 0101", q_empty); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (q_empty !== 4'hF) $display("FAIL mid_rst_empty: got %h, required f", q_empty); else passed++;
      total++; if (push_ready !== 4'hF) $display("FAIL mid_rst_ready: got %h, required f", push_ready); else passed++;
      total++; if (issue_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", issue_valid); else passed++;
      do_reset();
      tick();
   endtask

`ifdef SCHED_FLUSH_EN
   task automatic test_flush();
      do_reset();
      set_push(0, 20'h00600, 1'b0);
      set_push(2, 20'h00601, 1'b0);
      tick();
      idle();
      set_push(2, 20'h00602, 1'b0);
      tick();
      set_push(2, 20'h00603, 1'b0);
      tick();
      set_push(2, 20'h00604, 1'b0);
      flush[2] = 1'b1;
      ex_doing_mem = 1'b1;
      issue_ready = 1'b1;
      @(negedge clk);
      total++; if (issue_valid !== 1'b1 || issue_stream !== 2'd0)
         $display("FAIL flush_sel: got valid %b stream %0d, required valid 1 stream 0", issue_valid, issue_stream);
      else passed++;
      tick();
      idle();
      @(negedge clk);
      total++; if (q_empty[2] !== 1'b1) $display("FAIL flush_empty: got %b, required 1", q_empty[2]); else passed++;
      total++; if (issue_valid !== 1'b0) $display("FAIL flush_no_issue: got %b, required 0", issue_valid); else passed++;
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_slot();
      test_slot_blocked();
      test_rr();
      test_reset_mid();
`ifdef SCHED_FLUSH_EN
      test_flush();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
